// File: rtl/round_key_reader_pkg.sv
// Shared constants and types for the round-key read path.
package round_key_reader_pkg;
    localparam int RK_KEY_BITS  = 128;
    localparam int RK_ADDR_BITS = 4;
    localparam int RK_DEPTH     = 15;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic {
        RKR_IDLE  = 1'b0,
        RKR_SERVE = 1'b1
    } rkr_state_e;
endpackage

// File: rtl/round_key_ram.sv
// Simple dual-port key RAM: one write, one synchronous read-first read, no reset.
module round_key_ram #(
    parameter int KEY_BITS  = 128,
    parameter int ADDR_BITS = 4,
    parameter int DEPTH     = 15
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [KEY_BITS-1:0]  i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [KEY_BITS-1:0]  o_rdata
);
    logic [KEY_BITS-1:0] r_mem [DEPTH];

    // Read sees the pre-write contents when both ports hit one address.
    always_ff @(posedge clk) begin
        if (i_we && (i_waddr < ADDR_BITS'(DEPTH)))
            r_mem[i_waddr] <= i_wdata;
        if (i_re)
            o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/round_key_reader.sv
// Captures expanded round keys and streams them to the round engine in
// encrypt (0..Nr) or decrypt (Nr..0) order over valid/ready.
module round_key_reader
    import round_key_reader_pkg::*;
#(
    parameter int KEY_BITS  = RK_KEY_BITS,
    parameter int ADDR_BITS = RK_ADDR_BITS,
    parameter int DEPTH     = RK_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [KEY_BITS-1:0]  wr_key,
    input  logic                 wr_done,
    input  logic [ADDR_BITS-1:0] rounds_total,
    input  logic                 start,
    input  logic                 decrypt,
    output logic                 keys_ready,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [KEY_BITS-1:0]  rk_data,
    output logic [ADDR_BITS-1:0] rk_round,
    output logic                 rk_last,
    output logic                 busy
);
    rkr_state_e r_state, w_state_nx;

    logic                 r_keys_ready, r_done_pend;
    logic [ADDR_BITS-1:0] r_nr, r_nr_pend;

    logic                 r_dir, r_issued_all;
    logic [ADDR_BITS-1:0] r_idx;

    logic                 r_rd_vld, r_rd_last;
    logic [ADDR_BITS-1:0] r_rd_round;
    logic [KEY_BITS-1:0]  w_ram_rdata;

    logic [1:0]                      r_cnt;
    logic [1:0][KEY_BITS-1:0]        r_f_data;
    logic [1:0][ADDR_BITS-1:0]       r_f_round;
    logic [1:0]                      r_f_last;

    logic                 r_out_vld, r_out_last;
    logic [KEY_BITS-1:0]  r_out_data;
    logic [ADDR_BITS-1:0] r_out_round;

    logic w_wr0, w_serve, w_xfer, w_abort, w_finish, w_clr, w_start;
    logic w_issue, w_issue_last, w_load, w_pop, w_push;

    assign w_wr0    = wr_en && (wr_addr == '0);
    assign w_serve  = (r_state == RKR_SERVE);
    assign w_xfer   = r_out_vld && rk_ready;
    assign w_abort  = w_serve && w_wr0;
    assign w_finish = w_serve && w_xfer && r_out_last;
    assign w_clr    = w_abort || w_finish;
    // A write opening a new key set beats a same-cycle start.
    assign w_start  = (r_state == RKR_IDLE) && start && r_keys_ready && !w_wr0;

    // Keep RAM reads in flight plus buffered entries within the 2-deep buffer.
    assign w_issue      = w_serve && !w_abort && !r_issued_all &&
                          ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && !r_rd_vld));
    assign w_issue_last = r_dir ? (r_idx == '0) : (r_idx == r_nr);

    assign w_load = w_serve && !w_abort && (!r_out_vld || w_xfer) &&
                    ((r_cnt != 2'd0) || r_rd_vld);
    assign w_pop  = w_load && (r_cnt != 2'd0);
    assign w_push = w_serve && !w_abort && r_rd_vld && !(w_load && (r_cnt == 2'd0));

    round_key_ram #(
        .KEY_BITS (KEY_BITS),
        .ADDR_BITS(ADDR_BITS),
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (wr_en),
        .i_waddr(wr_addr),
        .i_wdata(wr_key),
        .i_re   (w_issue),
        .i_raddr(r_idx),
        .o_rdata(w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= RKR_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            RKR_IDLE:  if (w_start) w_state_nx = RKR_SERVE;
            RKR_SERVE: if (w_clr)   w_state_nx = RKR_IDLE;
            default:   w_state_nx = RKR_IDLE;
        endcase
    end

    // A wr_done seen mid-sequence is parked so nr stays fixed while serving.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys_ready <= 1'b0;
            r_done_pend  <= 1'b0;
            r_nr         <= '0;
            r_nr_pend    <= '0;
        end else if (w_wr0) begin
            r_keys_ready <= 1'b0;
            r_done_pend  <= 1'b0;
        end else if (wr_done) begin
            if (r_state == RKR_IDLE) begin
                r_nr         <= rounds_total;
                r_keys_ready <= 1'b1;
            end else begin
                r_nr_pend   <= rounds_total;
                r_done_pend <= 1'b1;
            end
        end else if (r_done_pend && (r_state == RKR_IDLE)) begin
            r_nr         <= r_nr_pend;
            r_keys_ready <= 1'b1;
            r_done_pend  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir        <= 1'b0;
            r_idx        <= '0;
            r_issued_all <= 1'b0;
        end else if (w_start) begin
            r_dir        <= decrypt;
            r_idx        <= decrypt ? r_nr : '0;
            r_issued_all <= 1'b0;
        end else if (w_issue) begin
            if (w_issue_last) r_issued_all <= 1'b1;
            else              r_idx <= r_dir ? r_idx - 1'b1 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clr) r_rd_vld <= 1'b0;
        else                r_rd_vld <= w_issue;
        if (w_issue) begin
            r_rd_round <= r_idx;
            r_rd_last  <= w_issue_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_clr)       r_cnt <= 2'd0;
        else if (w_pop && !w_push) r_cnt <= r_cnt - 2'd1;
        else if (w_push && !w_pop) r_cnt <= r_cnt + 2'd1;
        if (w_pop) begin
            r_f_data[0]  <= r_f_data[1];
            r_f_round[0] <= r_f_round[1];
            r_f_last[0]  <= r_f_last[1];
        end
        if (w_push) begin
            if ((r_cnt == 2'd0) || (w_pop && (r_cnt == 2'd1))) begin
                r_f_data[0]  <= w_ram_rdata;
                r_f_round[0] <= r_rd_round;
                r_f_last[0]  <= r_rd_last;
            end else begin
                r_f_data[1]  <= w_ram_rdata;
                r_f_round[1] <= r_rd_round;
                r_f_last[1]  <= r_rd_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_round <= '0;
        end else if (w_abort) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end else if (w_load) begin
            r_out_vld   <= 1'b1;
            r_out_data  <= w_pop ? r_f_data[0]  : w_ram_rdata;
            r_out_round <= w_pop ? r_f_round[0] : r_rd_round;
            r_out_last  <= w_pop ? r_f_last[0]  : r_rd_last;
        end else if (w_xfer) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
        end
    end

    assign keys_ready = r_keys_ready;
    assign rk_valid   = r_out_vld;
    assign rk_data    = r_out_data;
    assign rk_round   = r_out_round;
    assign rk_last    = r_out_last;
    assign busy       = w_serve;
endmodule

// File: tb/tb_round_key_reader.sv
// Scoreboard bench for round_key_reader: directed key sets, expected keys queued
// at start, a negedge monitor checks every transfer and stall stability.
module tb_round_key_reader;
    import round_key_reader_pkg::*;

    typedef struct packed {
        logic [127:0] data;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [127:0] wr_key;
    logic         wr_done;
    logic [3:0]   rounds_total;
    logic         start;
    logic         decrypt;
    logic         keys_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    round_key_reader dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_key      (wr_key),
        .wr_done     (wr_done),
        .rounds_total(rounds_total),
        .start       (start),
        .decrypt     (decrypt),
        .keys_ready  (keys_ready),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_round    (rk_round),
        .rk_last     (rk_last),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] key(input int sel, input int i);
        logic [7:0] b;
        b = 8'(i) + ((sel == 0) ? 8'h00 : (sel == 1) ? 8'h40 : 8'hC0);
        return {16{b}};
    endfunction

    // Monitor: every accepted beat must match the head of the queue.
    initial begin
        logic         stall_prev;
        logic [127:0] pd;
        logic [3:0]   pr;
        logic         pl;
        exp_t         e;
        stall_prev = 1'b0;
        pd = '0; pr = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_prev && !reset) begin
                chk("hold_valid", 128'(rk_valid), 128'(1'b1));
                chk("hold_data",  rk_data, pd);
                chk("hold_round", 128'(rk_round), 128'(pr));
                chk("hold_last",  128'(rk_last), 128'(pl));
            end
            if (rk_valid && rk_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer actual_round=%0d expected=no_transfer", rk_round);
                end else begin
                    e = q.pop_front();
                    chk("xfer_data",  rk_data, e.data);
                    chk("xfer_round", 128'(rk_round), 128'(e.round));
                    chk("xfer_last",  128'(rk_last), 128'(e.last));
                end
            end
            stall_prev = rk_valid && !rk_ready;
            pd = rk_data; pr = rk_round; pl = rk_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_keys(input int sel, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_key = key(sel, i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic do_done(input int nr);
        wr_done = 1'b1; rounds_total = 4'(nr);
        tick();
        wr_done = 1'b0;
    endtask

    task automatic push_seq(input int sel, input int nr, input bit dec);
        exp_t e;
        for (int k = 0; k <= nr; k++) begin
            int idx;
            idx = dec ? nr - k : k;
            e.data = key(sel, idx); e.round = 4'(idx); e.last = (k == nr);
            q.push_back(e);
        end
    endtask

    task automatic pulse_start(input bit dec);
        start = 1'b1; decrypt = dec;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name, input int maxc);
        for (int c = 0; c < maxc; c++) begin
            if (q.size() == 0 && !busy) break;
            tick();
        end
        chk({name, "_left"}, 128'(q.size()), 128'(0));
        chk({name, "_busy"}, 128'(busy), 128'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_keys_ready"}, 128'(keys_ready), 128'(0));
        chk({tag, "_valid"},      128'(rk_valid), 128'(0));
        chk({tag, "_last"},       128'(rk_last), 128'(0));
        chk({tag, "_busy"},       128'(busy), 128'(0));
        chk({tag, "_round"},      128'(rk_round), 128'(0));
        chk({tag, "_data"},       rk_data, 128'(0));
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_key = '0; wr_done = 1'b0;
        rounds_total = '0; start = 1'b0; decrypt = 1'b0; rk_ready = 1'b1;
        tick(); tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // AES-128 key set; start before wr_done must be ignored
        write_keys(0, 0, NR_AES128);
        pulse_start(1'b0);
        chk("early_start_busy", 128'(busy), 128'(0));
        repeat (3) tick();
        chk("early_start_valid", 128'(rk_valid), 128'(0));
        chk("early_keys_ready", 128'(keys_ready), 128'(0));
        do_done(NR_AES128);
        chk("keys_ready_128", 128'(keys_ready), 128'(1));

        // Encrypt, full-rate: valid two edges after start, 11 beats back to back
        push_seq(0, NR_AES128, 1'b0);
        pulse_start(1'b0);
        chk("lat_e0_valid", 128'(rk_valid), 128'(0));
        chk("lat_e0_busy",  128'(busy), 128'(1));
        tick();
        chk("lat_e1_valid", 128'(rk_valid), 128'(0));
        tick();
        chk("lat_e2_valid", 128'(rk_valid), 128'(1));
        chk("lat_e2_round", 128'(rk_round), 128'(0));
        chk("lat_e2_data",  rk_data, key(0, 0));
        repeat (11) tick();
        chk("enc_back_to_back_left", 128'(q.size()), 128'(0));
        chk("enc_end_valid", 128'(rk_valid), 128'(0));
        chk("enc_end_busy",  128'(busy), 128'(0));
        chk("enc_end_keys_ready", 128'(keys_ready), 128'(1));

        // Same set, decrypt order
        push_seq(0, NR_AES128, 1'b1);
        pulse_start(1'b1);
        drain("dec128", 40);

        // AES-256 with random backpressure; a start mid-sequence is ignored
        write_keys(1, 0, NR_AES256);
        do_done(NR_AES256);
        push_seq(1, NR_AES256, 1'b0);
        pulse_start(1'b0);
        for (int c = 0; c < 300; c++) begin
            if (q.size() == 0 && !busy) break;
            rk_ready = 1'($urandom_range(0, 1));
            start = (c == 6);
            tick();
        end
        start = 1'b0;
        rk_ready = 1'b1;
        drain("rand256", 5);

        // Abort: write to address 0 while serving
        push_seq(1, NR_AES256, 1'b0);
        pulse_start(1'b0);
        tick(); tick(); tick();
        wr_en = 1'b1; wr_addr = 4'd0; wr_key = key(2, 0);
        tick();
        wr_en = 1'b0;
        chk("abort_valid", 128'(rk_valid), 128'(0));
        chk("abort_busy",  128'(busy), 128'(0));
        chk("abort_keys_ready", 128'(keys_ready), 128'(0));
        chk("abort_remaining", 128'(q.size()), 128'(13));
        q.delete();
        repeat (3) tick();
        chk("abort_quiet_valid", 128'(rk_valid), 128'(0));
        write_keys(2, 1, NR_AES192);
        do_done(NR_AES192);
        chk("keys_ready_192", 128'(keys_ready), 128'(1));
        push_seq(2, NR_AES192, 1'b1);
        pulse_start(1'b1);
        drain("dec192_new", 40);

        // Reset while the fifth key is presented
        push_seq(2, NR_AES192, 1'b0);
        pulse_start(1'b0);
        repeat (6) tick();
        chk("fifth_key_round", 128'(rk_round), 128'(4));
        reset = 1'b1;
        tick();
        chk_reset_vals("midreset");
        reset = 1'b0;
        q.delete();
        pulse_start(1'b0);
        repeat (4) tick();
        chk("post_reset_start_valid", 128'(rk_valid), 128'(0));
        chk("post_reset_start_busy",  128'(busy), 128'(0));
        do_done(NR_AES192);
        push_seq(2, NR_AES192, 1'b0);
        pulse_start(1'b0);
        drain("enc192_restart", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
